// File: rtl/ishift_gen.sv
// Multi-cycle shifter/rotator: CHUNK-bit strides while enough count remains, then 1-bit steps.
// Produces a last-bit-out carry and a one-cycle done strobe; abort cancels without done.
module ishift_gen #(
    parameter int WIDTH  = 32,
    parameter int CWIDTH = 6,
    parameter int CHUNK  = 6
) (
    input  logic              clk,
    input  logic              arstn,
    input  logic              go,
    input  logic              abort,
    input  logic [2:0]        fmt,
    input  logic [CWIDTH-1:0] cnt,
    input  logic [WIDTH-1:0]  a,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  y,
    output logic              cy
);

    // Field width for ROR32; only meaningful when WIDTH >= 32.
    localparam int RW = (WIDTH >= 32) ? 32 : WIDTH;

    logic [WIDTH-1:0]  r_y;
    logic              r_cy;
    logic              r_busy;
    logic              r_done;
    logic [CWIDTH-1:0] r_rem;
    logic [2:0]        r_fmt;

    logic [CWIDTH-1:0] w_n;
    logic              w_use_big;
    logic [CWIDTH-1:0] w_step;
    logic [WIDTH:0]    w_big;
    logic [WIDTH:0]    w_one;
    logic [WIDTH:0]    w_nxt;

    // Returns {carry, result} for one step of s bits; s is a constant at each call site.
    function automatic logic [WIDTH:0] step_fn(input logic [WIDTH-1:0] v, input logic [2:0] f,
                                               input int s);
        logic [WIDTH-1:0] r;
        logic [WIDTH-1:0] lo_out;
        logic [WIDTH-1:0] hi_out;
        logic [RW-1:0]    fld;
        logic             c;
        lo_out = v >> (s - 1);
        hi_out = v << (s - 1);
        fld    = v[RW-1:0];
        r      = v >> s;
        c      = lo_out[0];
        case (f)
            3'b001: begin r = v << s; c = hi_out[WIDTH-1]; end
            3'b010: begin r = $signed(v) >>> s; c = lo_out[0]; end
            3'b011: begin r = (v << s) | (v >> (WIDTH - s)); c = hi_out[WIDTH-1]; end
            3'b100: begin r = (v >> s) | (v << (WIDTH - s)); c = lo_out[0]; end
            3'b101: begin
                fld = (fld >> s) | (fld << (RW - s));
                r = v;
                r[RW-1:0] = fld;
                c = lo_out[0];
            end
            default: ;
        endcase
        return {c, r};
    endfunction

    always_comb begin
        w_n = cnt;
        case (fmt)
            3'b011, 3'b100: w_n = cnt & CWIDTH'(WIDTH - 1);
            3'b101:         w_n = cnt & CWIDTH'(31);
            default:        w_n = (cnt > CWIDTH'(WIDTH)) ? CWIDTH'(WIDTH) : cnt;
        endcase
    end

    assign w_use_big = (r_rem >= CWIDTH'(CHUNK));
    assign w_step    = w_use_big ? CWIDTH'(CHUNK) : CWIDTH'(1);
    assign w_big     = step_fn(r_y, r_fmt, CHUNK);
    assign w_one     = step_fn(r_y, r_fmt, 1);
    assign w_nxt     = w_use_big ? w_big : w_one;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_y    <= '0;
            r_cy   <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_rem  <= '0;
            r_fmt  <= 3'b000;
        end else begin
            r_done <= 1'b0;
            if (r_busy) begin
                if (abort) begin
                    r_busy <= 1'b0;
                    r_rem  <= '0;
                end else begin
                    r_y   <= w_nxt[WIDTH-1:0];
                    r_cy  <= w_nxt[WIDTH];
                    r_rem <= r_rem - w_step;
                    if (r_rem == w_step) begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                    end
                end
            end else if (go && !abort) begin
                r_y   <= a;
                r_cy  <= 1'b0;
                r_fmt <= fmt;
                r_rem <= w_n;
                if (w_n == '0) r_done <= 1'b1;
                else           r_busy <= 1'b1;
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign y    = r_y;
    assign cy   = r_cy;

endmodule

// File: tb/tb_ishift_gen.sv
// Directed bench for ishift_gen: 32-bit table vectors, abort/go/reset sequences, 64-bit cases.
module tb_ishift_gen;

    logic        clk = 1'b0;
    logic        arstn = 1'b0;

    logic        go32 = 1'b0, abort32 = 1'b0;
    logic [2:0]  fmt32 = '0;
    logic [5:0]  cnt32 = '0;
    logic [31:0] a32 = '0;
    logic        busy32, done32, cy32;
    logic [31:0] y32;

    logic        go64 = 1'b0, abort64 = 1'b0;
    logic [2:0]  fmt64 = '0;
    logic [6:0]  cnt64 = '0;
    logic [63:0] a64 = '0;
    logic        busy64, done64, cy64;
    logic [63:0] y64;

    int nvec = 0;
    int nmis = 0;

    always #5 clk = ~clk;

    ishift_gen #(.WIDTH(32), .CWIDTH(6), .CHUNK(6)) u_dut32 (
        .clk(clk), .arstn(arstn), .go(go32), .abort(abort32), .fmt(fmt32), .cnt(cnt32),
        .a(a32), .busy(busy32), .done(done32), .y(y32), .cy(cy32)
    );

    ishift_gen #(.WIDTH(64), .CWIDTH(7), .CHUNK(6)) u_dut64 (
        .clk(clk), .arstn(arstn), .go(go64), .abort(abort64), .fmt(fmt64), .cnt(cnt64),
        .a(a64), .busy(busy64), .done(done64), .y(y64), .cy(cy64)
    );

    typedef struct {
        string       nm;
        logic [2:0]  f;
        logic [5:0]  c;
        logic [31:0] a;
        logic [31:0] ey;
        logic        ecy;
        int          ecyc;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Starts one op (in the current cycle), counts busy cycles, then checks done/y/cy.
    task automatic run_op(input bit w64, input string nm, input logic [2:0] f, input logic [6:0] c,
                          input logic [63:0] av, input logic [63:0] ey, input logic ecy,
                          input int ecyc);
        int cyc = 0;
        if (w64) begin
            go64 = 1'b1; fmt64 = f; cnt64 = c; a64 = av;
        end else begin
            go32 = 1'b1; fmt32 = f; cnt32 = c[5:0]; a32 = av[31:0];
        end
        @(posedge clk); #1;
        go32 = 1'b0; go64 = 1'b0;
        while ((w64 ? busy64 : busy32) && cyc < 300) begin
            cyc++;
            @(posedge clk); #1;
        end
        chk({nm, ".cycles"}, 64'(cyc), 64'(ecyc));
        chk({nm, ".done"}, 64'(w64 ? done64 : done32), 64'd1);
        chk({nm, ".y"}, w64 ? y64 : 64'(y32), ey);
        chk({nm, ".cy"}, 64'(w64 ? cy64 : cy32), 64'(ecy));
    endtask

    initial begin
        tbl[0]  = '{"lsr13",  3'd0, 6'd13, 32'h8000_0001, 32'h0004_0000, 1'b0, 3};
        tbl[1]  = '{"asr40",  3'd2, 6'd40, 32'hF000_0000, 32'hFFFF_FFFF, 1'b1, 7};
        tbl[2]  = '{"rol33",  3'd3, 6'd33, 32'h8000_0001, 32'h0000_0003, 1'b1, 1};
        tbl[3]  = '{"ror4",   3'd4, 6'd4,  32'h0000_0001, 32'h1000_0000, 1'b0, 4};
        tbl[4]  = '{"lsl0",   3'd1, 6'd0,  32'h1234_5678, 32'h1234_5678, 1'b0, 0};
        tbl[5]  = '{"lsr40",  3'd0, 6'd40, 32'h8000_0000, 32'h0000_0000, 1'b1, 7};
        tbl[6]  = '{"lsl32",  3'd1, 6'd32, 32'h0000_0001, 32'h0000_0000, 1'b1, 7};
        tbl[7]  = '{"rsv4",   3'd6, 6'd4,  32'h0000_00F0, 32'h0000_000F, 1'b0, 4};
        tbl[8]  = '{"rol32",  3'd3, 6'd32, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 0};
        tbl[9]  = '{"ror12",  3'd4, 6'd12, 32'h0000_0ABC, 32'hABC0_0000, 1'b1, 2};
        tbl[10] = '{"asr8",   3'd2, 6'd8,  32'h7FFF_FFFF, 32'h007F_FFFF, 1'b1, 3};
        tbl[11] = '{"rol7",   3'd3, 6'd7,  32'h8100_0000, 32'h8000_0040, 1'b0, 2};
        tbl[12] = '{"ror32",  3'd5, 6'd37, 32'h0000_001F, 32'hF800_0000, 1'b1, 5};

        repeat (2) @(posedge clk);
        #1;
        chk("rst.busy", 64'(busy32), 64'd0);
        chk("rst.done", 64'(done32), 64'd0);
        chk("rst.y", 64'(y32), 64'd0);
        chk("rst.cy", 64'(cy32), 64'd0);
        arstn = 1'b1;
        @(posedge clk); #1;

        // Each vector starts in the done cycle of the previous one (back-to-back accept).
        for (int i = 0; i < 13; i++)
            run_op(1'b0, tbl[i].nm, tbl[i].f, {1'b0, tbl[i].c}, {32'h0, tbl[i].a},
                   {32'h0, tbl[i].ey}, tbl[i].ecy, tbl[i].ecyc);
        @(posedge clk); #1;
        chk("done.pulse", 64'(done32), 64'd0);

        // go during busy is ignored; abort ends the op with no done.
        go32 = 1'b1; fmt32 = 3'd0; cnt32 = 6'd31; a32 = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        go32 = 1'b0;
        chk("abt.busy1", 64'(busy32), 64'd1);
        @(posedge clk); #1;
        go32 = 1'b1; a32 = 32'h0; cnt32 = 6'd1;
        @(posedge clk); #1;
        go32 = 1'b0; abort32 = 1'b1;
        chk("abt.busy3", 64'(busy32), 64'd1);
        @(posedge clk); #1;
        abort32 = 1'b0;
        chk("abt.busy", 64'(busy32), 64'd0);
        chk("abt.done", 64'(done32), 64'd0);
        chk("abt.y", 64'(y32), 64'h000F_FFFF);
        chk("abt.cy", 64'(cy32), 64'd1);
        @(posedge clk); #1;
        chk("abt.nodone", 64'(done32), 64'd0);
        run_op(1'b0, "post_abt", 3'd0, 7'd8, 64'h100, 64'h1, 1'b0, 3);

        // abort with go while idle: go ignored.
        @(posedge clk); #1;
        go32 = 1'b1; abort32 = 1'b1; a32 = 32'h55; cnt32 = 6'd0;
        @(posedge clk); #1;
        go32 = 1'b0; abort32 = 1'b0;
        chk("idleabt.busy", 64'(busy32), 64'd0);
        chk("idleabt.done", 64'(done32), 64'd0);
        chk("idleabt.y", 64'(y32), 64'h1);

        // Asynchronous reset mid-operation.
        go32 = 1'b1; fmt32 = 3'd0; cnt32 = 6'd31; a32 = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        go32 = 1'b0;
        @(posedge clk); #1;
        arstn = 1'b0;
        #1;
        chk("arst.busy", 64'(busy32), 64'd0);
        chk("arst.done", 64'(done32), 64'd0);
        chk("arst.y", 64'(y32), 64'd0);
        chk("arst.cy", 64'(cy32), 64'd0);
        #2 arstn = 1'b1;
        @(posedge clk); #1;
        chk("arst.nodone1", 64'(done32), 64'd0);
        @(posedge clk); #1;
        chk("arst.nodone2", 64'(done32), 64'd0);
        run_op(1'b0, "post_rst", 3'd1, 7'd4, 64'h1, 64'h10, 1'b0, 4);

        // 64-bit instance.
        run_op(1'b1, "w64.ror32", 3'd5, 7'd36, 64'hAAAA_BBBB_0000_0001,
               64'hAAAA_BBBB_1000_0000, 1'b0, 4);
        run_op(1'b1, "w64.lsl63", 3'd1, 7'd63, 64'h1, 64'h8000_0000_0000_0000, 1'b0, 13);
        run_op(1'b1, "w64.lsr100", 3'd0, 7'd100, 64'h8000_0000_0000_0000, 64'h0, 1'b1, 14);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/ishift_gen.md
Name: ishift_gen

Overview:
Parametrised multi-cycle barrel-shifter replacement for the CPU ALU. It shifts or rotates WIDTH-bit operands in CHUNK-bit strides, then finishes with 1-bit steps. Compared with the previous shifter it adds:
- full-width rotate left/right;
- count saturation;
- a carry (last-bit-out) flag;
- a done strobe, an abort input, and a reset value on the result.

Parameters:
WIDTH, 32, operand width; power of two, 16..64.
CWIDTH, 6, count width; must satisfy 2^CWIDTH > WIDTH.
CHUNK, 6, large-step stride; 2..WIDTH/2.

Ports:
clk  in  1  clock, all state on rising edge
arstn  in  1  async reset, active low
go  in  1  start request; accepted only when busy=0 and abort=0
abort  in  1  synchronous cancel of an operation in progress
fmt  in  3  shift format, sampled on accept
cnt  in  CWIDTH  shift count, sampled on accept
a  in  WIDTH  operand, sampled on accept
busy  out  1  1 while steps remain
done  out  1  one-cycle strobe: y and cy valid
y  out  WIDTH  result
cy  out  1  last bit shifted or rotated out

Behaviour:
- Reset (arstn=0, async, also mid-operation): busy=0, done=0, y=0, cy=0, remaining=0, format=000. No done strobe follows a reset.
- Formats:
  - 000 LSR.
  - 001 LSL.
  - 010 ASR (sign fill from y[WIDTH-1]).
  - 011 ROL full width.
  - 100 ROR full width.
  - 101 ROR32: rotates y[31:0], holds y[WIDTH-1:32]; illegal if WIDTH<32.
  - 11x reserved, behaves as 000.
- Effective count n:
  - Shifts (000/001/010/11x): n = min(cnt, WIDTH).
  - ROL/ROR: n = cnt mod WIDTH.
  - ROR32: n = cnt mod 32.
- Accept edge (go=1, busy=0, abort=0):
  - y<=a, cy<=0; latch format; remaining<=n.
  - If n=0: busy stays 0 and done=1 in the following cycle.
  - Else: busy<=1.
- Step edges (busy=1):
  - If remaining>=CHUNK: shift/rotate by CHUNK, remaining-=CHUNK.
  - Else: shift/rotate by 1, remaining-=1.
  - On the edge where remaining reaches 0: busy<=0, done<=1 for exactly one cycle.
- Latency: busy high for floor(n/CHUNK)+(n mod CHUNK) cycles. done is high in the cycle after the last step edge.
- Carry on each step, taken from the pre-step value:
  - Right shifts: bit STEP-1.
  - LSL: bit WIDTH-STEP.
  - ROR/ROR32: bit STEP-1 (lands at the field MSB).
  - ROL: bit WIDTH-STEP (lands at bit 0).
  - cy holds its last value until the next accept.
- y and cy are stable between done and the next accept; y is undefined-in-progress while busy=1.
- go while busy=1: ignored, with no effect on state.
- go in the same cycle as done: legal; starts a new operation (busy=0 at that point).
- abort while busy=1: next edge forces busy=0 and remaining=0; no done; y and cy keep their partial values. abort while idle: no effect. abort and go in the same cycle: go is ignored.
- Arithmetic shift by n=WIDTH: y = all copies of the sign bit, cy = sign bit. LSR/LSL by WIDTH: y=0, cy = a[WIDTH-1] (LSR) or a[0] (LSL).

Test Plan:
1. W=32: LSR, a=0x8000_0001, cnt=13 -> busy high for 3 cycles (6,6,1), then done; y=0x0004_0000, cy=0.
2. W=32: ASR, a=0xF000_0000, cnt=40 -> clamped to 32; 7 busy cycles; y=0xFFFF_FFFF, cy=1.
3. W=32: ROL, a=0x8000_0001, cnt=33 -> n=1; y=0x0000_0003, cy=1. Also ROR, a=0x0000_0001, cnt=4 -> y=0x1000_0000, cy=0.
4. W=32: LSL, a=0x1234_5678, cnt=0 -> busy never asserts; done one cycle after the accept edge; y=0x1234_5678, cy=0. Then a back-to-back go in the done cycle is accepted.
5. LSR, cnt=31; pulse go again at busy cycle 2 -> ignored. abort at busy cycle 3 -> busy=0 next edge, no done. A new go then completes normally. Repeat with arstn low mid-operation -> y=0, busy=0, done=0 immediately.
6. W=64 instance: ROR32, a=0xAAAA_BBBB_0000_0001, cnt=36 -> n=4; y=0xAAAA_BBBB_1000_0000, cy=0. Also LSL, a=1, cnt=63 -> y=0x8000_0000_0000_0000, 10+3=13 busy cycles.
